// File: rtl/audio_nios_pkg.sv
// Shared definitions for the audio subsystem's system-ID checker:
// sequencer state encoding and the two system-ID slave word addresses.
package audio_nios_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD0_REQ  = 3'd1,
        ST_RD0_WAIT = 3'd2,
        ST_RD1_REQ  = 3'd3,
        ST_RD1_WAIT = 3'd4,
        ST_CHECK    = 3'd5
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/audio_nios_sysid_checker.sv
// Avalon-MM read sequencer: fetches system-ID word 0 (ID) and word 1 (timestamp),
// compares both with build-time values and reports pass / mismatch / timeout.
module audio_nios_sysid_checker
    import audio_nios_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1400229183,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        id_mismatch,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    sysid_state_t     r_state;
    sysid_state_t     w_state_next;
    logic [TMO_W-1:0] r_tmo;
    logic [RTY_W-1:0] r_retry;
    logic             r_auto_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_id_ok;
    logic             r_id_mismatch;
    logic             r_timeout_err;
    logic [31:0]      r_id_value;
    logic [31:0]      r_ts_value;

    logic             w_in_req;
    logic             w_in_wait;
    logic             w_launch;
    logic             w_accept;
    logic             w_resp;
    logic [TMO_W-1:0] w_tmo_inc;
    logic             w_timeout;
    logic             w_retry;
    logic             w_giveup;
    logic             w_match;

    assign w_in_req  = (r_state == ST_RD0_REQ)  || (r_state == ST_RD1_REQ);
    assign w_in_wait = (r_state == ST_RD0_WAIT) || (r_state == ST_RD1_WAIT);
    // A start coinciding with the done pulse belongs to the finished check and is dropped.
    assign w_launch  = (r_state == ST_IDLE) && ((start && !r_done) || r_auto_pend);
    assign w_accept  = w_in_req && !avm_waitrequest;
    assign w_resp    = w_in_wait && avm_readdatavalid;
    assign w_tmo_inc = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TMO_W'(1);
    // Progress in the expiry cycle wins over the timeout.
    assign w_timeout = (w_in_req || w_in_wait) && (w_tmo_inc == TMO_MAX) && !w_accept && !w_resp;
    assign w_retry   = w_timeout && (r_retry < RTY_MAX);
    assign w_giveup  = w_timeout && !(r_retry < RTY_MAX);
    assign w_match   = (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_launch) w_state_next = ST_RD0_REQ;
            ST_RD0_REQ:  if (w_accept) w_state_next = ST_RD0_WAIT;
            ST_RD0_WAIT: if (w_resp)   w_state_next = ST_RD1_REQ;
            ST_RD1_REQ:  if (w_accept) w_state_next = ST_RD1_WAIT;
            ST_RD1_WAIT: if (w_resp)   w_state_next = ST_CHECK;
            ST_CHECK:    w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
        if (w_retry) begin
            w_state_next = ST_RD0_REQ;
        end else if (w_giveup) begin
            w_state_next = ST_IDLE;
        end
    end

    always_comb begin
        avm_read    = 1'b0;
        avm_address = SYSID_ADDR_ID;
        unique case (r_state)
            ST_RD0_REQ:  avm_read = 1'b1;
            ST_RD1_REQ: begin
                avm_read    = 1'b1;
                avm_address = SYSID_ADDR_TS;
            end
            ST_RD1_WAIT: avm_address = SYSID_ADDR_TS;
            default:     avm_read = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo         <= '0;
            r_retry       <= '0;
            r_auto_pend   <= (AUTO_START != 0);
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_id_mismatch <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_launch) begin
                r_auto_pend   <= 1'b0;
                r_busy        <= 1'b1;
                r_id_ok       <= 1'b0;
                r_id_mismatch <= 1'b0;
                r_timeout_err <= 1'b0;
                r_retry       <= '0;
            end
            // The per-read budget restarts whenever a REQ state is entered.
            if (w_launch || w_resp || w_retry) begin
                r_tmo <= '0;
            end else if (w_in_req || w_in_wait) begin
                r_tmo <= w_tmo_inc;
            end
            if (w_retry) begin
                r_retry <= r_retry + RTY_W'(1);
            end
            if (w_giveup) begin
                r_timeout_err <= 1'b1;
                r_done        <= 1'b1;
                r_busy        <= 1'b0;
            end
            if (w_resp && (r_state == ST_RD0_WAIT)) begin
                r_id_value <= avm_readdata;
            end
            if (w_resp && (r_state == ST_RD1_WAIT)) begin
                r_ts_value <= avm_readdata;
            end
            if (r_state == ST_CHECK) begin
                r_id_ok       <= w_match;
                r_id_mismatch <= !w_match;
                r_done        <= 1'b1;
                r_busy        <= 1'b0;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign id_mismatch = r_id_mismatch;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_audio_nios_sysid_checker.sv
// Bench for the system-ID checker: an Avalon slave model with configurable stall, latency
// and dropped reads drives dut0; dut1 (no auto start) is driven by hand for the reset case.
module tb_audio_nios_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1400229183;
    localparam int T = 15;
    localparam int R = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s0_start = 1'b0;
    logic        a0_addr, a0_read;
    logic        a0_wr = 1'b0;
    logic        a0_rdv = 1'b0;
    logic [31:0] a0_rdata = 32'd0;
    logic        b0_busy, b0_done, b0_ok, b0_mism, b0_tmo;
    logic [31:0] b0_id, b0_ts;

    logic        s1_start = 1'b0;
    logic        a1_addr, a1_read;
    logic        a1_wr = 1'b0;
    logic        a1_rdv = 1'b0;
    logic [31:0] a1_rdata = 32'd0;
    logic        b1_busy, b1_done, b1_ok, b1_mism, b1_tmo;
    logic [31:0] b1_id, b1_ts;

    audio_nios_sysid_checker #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(R), .AUTO_START(1)) dut0 (
        .clock(clk), .reset_n(rst0_n), .start(s0_start),
        .avm_address(a0_addr), .avm_read(a0_read), .avm_waitrequest(a0_wr),
        .avm_readdatavalid(a0_rdv), .avm_readdata(a0_rdata),
        .busy(b0_busy), .done(b0_done), .id_ok(b0_ok), .id_mismatch(b0_mism),
        .timeout_err(b0_tmo), .id_value(b0_id), .ts_value(b0_ts)
    );

    audio_nios_sysid_checker #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(R), .AUTO_START(0)) dut1 (
        .clock(clk), .reset_n(rst1_n), .start(s1_start),
        .avm_address(a1_addr), .avm_read(a1_read), .avm_waitrequest(a1_wr),
        .avm_readdatavalid(a1_rdv), .avm_readdata(a1_rdata),
        .busy(b1_busy), .done(b1_done), .id_ok(b1_ok), .id_mismatch(b1_mism),
        .timeout_err(b1_tmo), .id_value(b1_id), .ts_value(b1_ts)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model configuration (per word address) and state.
    int          cfg_s [2] = '{0, 0};
    int          cfg_d [2] = '{1, 1};
    logic [31:0] cfg_data [2] = '{EXP_ID, EXP_TS};
    int          drop_left = 0;
    bit          in_req = 0;
    logic        req_addr = 1'b0;
    int          stall_left = 0;
    bit          pend = 0;
    int          pend_cyc = 0;
    logic        pend_addr = 1'b0;

    always @(negedge clk) begin
        a0_rdv   = 1'b0;
        a0_rdata = $urandom;
        if (!rst0_n) begin
            in_req = 0;
            pend   = 0;
            a0_wr  = 1'b0;
        end else begin
            if (pend && cyc == pend_cyc) begin
                a0_rdv   = 1'b1;
                a0_rdata = cfg_data[pend_addr];
                pend     = 0;
            end
            if (a0_read === 1'b1) begin
                if (!in_req || req_addr != a0_addr) begin
                    in_req     = 1;
                    req_addr   = a0_addr;
                    stall_left = cfg_s[a0_addr];
                end
                if (stall_left > 0) begin
                    a0_wr = 1'b1;
                    stall_left--;
                end else begin
                    a0_wr  = 1'b0;
                    in_req = 0;
                    if (drop_left > 0) begin
                        drop_left--;
                    end else begin
                        pend      = 1;
                        pend_cyc  = cyc + cfg_d[a0_addr];
                        pend_addr = a0_addr;
                    end
                end
            end else begin
                a0_wr  = 1'b0;
                in_req = 0;
            end
        end
    end

    task automatic set_slave(input int s0, input int d0, input int s1, input int d1,
                             input logic [31:0] id, input logic [31:0] ts, input int drop);
        cfg_s[0] = s0; cfg_d[0] = d0; cfg_s[1] = s1; cfg_d[1] = d1;
        cfg_data[0] = id; cfg_data[1] = ts; drop_left = drop;
    endtask

    // Reference: walks reads as whole units; a read finishes in stall+1+latency cycles or is
    // abandoned after T cycles; an abandoned read restarts the sequence while retries remain.
    task automatic model_run(input int s0, input int d0, input int s1, input int d1, input int drop,
                             output int lat, output bit tmo, output bit cap0, output bit cap1);
        int t, att, dl, need, s, d;
        bit ok_seq;
        t = 1; att = 0; dl = drop; cap0 = 0; cap1 = 0; lat = 0; tmo = 0;
        forever begin
            ok_seq = 1;
            for (int n = 0; n < 2; n++) begin
                s = (n == 0) ? s0 : s1;
                d = (n == 0) ? d0 : d1;
                if (dl > 0) begin
                    dl--;
                    need = T + 1000;
                end else begin
                    need = s + 1 + d;
                end
                if (need <= T) begin
                    t += need;
                    if (n == 0) cap0 = 1; else cap1 = 1;
                end else begin
                    t += T;
                    ok_seq = 0;
                    break;
                end
            end
            if (ok_seq) begin
                lat = t + 1;
                return;
            end
            att++;
            if (att > R) begin
                lat = t;
                tmo = 1;
                return;
            end
        end
    endtask

    // Pulses (or holds) start on dut0, then watches for done; lat=-1 if done never arrives.
    task automatic launch_and_wait(input bit hold_start, output int lat, output int ndone,
                                   output int viol);
        int   st, first;
        bit   p_read, p_wr;
        logic p_addr;
        first = -1; ndone = 0; viol = 0; p_read = 0; p_wr = 0; p_addr = 1'b0;
        @(negedge clk); #1;
        s0_start = 1'b1;
        st = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            s0_start = hold_start ? (b0_busy | b0_done) : 1'b0;
            if (p_read && p_wr && (a0_read !== 1'b1 || a0_addr !== p_addr)) viol++;
            p_read = (a0_read === 1'b1); p_wr = (a0_wr === 1'b1); p_addr = a0_addr;
            if (b0_done === 1'b1) begin
                ndone++;
                if (first < 0) first = cyc;
            end
            if (first >= 0 && cyc >= first + 12) break;
        end
        s0_start = 1'b0;
        lat = (first < 0) ? -1 : first - st;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk); #1;
        n_checks++;
        if ({b0_busy, b0_done, b0_ok, b0_mism, b0_tmo, a0_read} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags0: got %b required 000000", {b0_busy, b0_done, b0_ok, b0_mism, b0_tmo, a0_read});
        end
        n_checks++;
        if ({b0_id, b0_ts, b1_id, b1_ts} !== 128'd0) begin
            n_fail++; $display("FAIL reset_values: got %h %h %h %h required 0", b0_id, b0_ts, b1_id, b1_ts);
        end
        rst1_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if ({b1_busy, b1_done, b1_ok, b1_mism, b1_tmo, a1_read} !== 6'b0) begin
            n_fail++; $display("FAIL no_autostart: got %b required 000000", {b1_busy, b1_done, b1_ok, b1_mism, b1_tmo, a1_read});
        end
        $display("reset: dut0 held, dut1 released and idle");
    endtask

    task automatic test_autostart;
        int rel, first;
        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, 0);
        @(negedge clk); #1;
        rst0_n = 1'b1;
        rel = cyc; first = -1;
        for (int i = 0; i < 50 && first < 0; i++) begin
            @(negedge clk); #1;
            if (b0_done === 1'b1) first = cyc;
        end
        n_checks++;
        if (first - rel !== 6 || first < 0) begin
            n_fail++; $display("FAIL autostart_latency: got %0d required 6", (first < 0) ? -1 : first - rel);
        end
        n_checks++;
        if ({b0_ok, b0_mism, b0_tmo, b0_busy} !== 4'b1000) begin
            n_fail++; $display("FAIL autostart_status: got ok/mism/tmo/busy=%b required 1000", {b0_ok, b0_mism, b0_tmo, b0_busy});
        end
        n_checks++;
        if (b0_ts !== EXP_TS || b0_id !== EXP_ID) begin
            n_fail++; $display("FAIL autostart_values: got id=%0d ts=%0d required %0d %0d", b0_id, b0_ts, EXP_ID, EXP_TS);
        end
        $display("autostart: done %0d cycles after release", first - rel);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mismatch;
        int lat, nd, v;
        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS + 32'd1, 0);
        launch_and_wait(0, lat, nd, v);
        n_checks++;
        if ({b0_ok, b0_mism, b0_tmo} !== 3'b010) begin
            n_fail++; $display("FAIL mismatch_status: got ok/mism/tmo=%b required 010", {b0_ok, b0_mism, b0_tmo});
        end
        n_checks++;
        if (b0_ts !== EXP_TS + 32'd1) begin
            n_fail++; $display("FAIL mismatch_ts: got %0d required %0d", b0_ts, EXP_TS + 32'd1);
        end
        n_checks++;
        if (nd !== 1 || lat !== 6) begin
            n_fail++; $display("FAIL mismatch_done: got %0d pulses latency %0d required 1 pulse latency 6", nd, lat);
        end
        $display("mismatch: latency %0d, done pulses %0d", lat, nd);
    endtask

    task automatic test_stall;
        int lat, nd, v, elat;
        bit etmo, c0, c1;
        set_slave(10, 1, 10, 1, EXP_ID, EXP_TS, 0);
        model_run(10, 1, 10, 1, 0, elat, etmo, c0, c1);
        launch_and_wait(0, lat, nd, v);
        n_checks++;
        if (lat !== elat || b0_ok !== 1'b1 || b0_tmo !== 1'b0) begin
            n_fail++; $display("FAIL stall_pass: got latency %0d ok %b tmo %b required %0d 1 0", lat, b0_ok, b0_tmo, elat);
        end
        n_checks++;
        if (v !== 0) begin
            n_fail++; $display("FAIL stall_stable: got %0d request changes during stall required 0", v);
        end
        $display("stall: latency %0d (model %0d)", lat, elat);
    endtask

    task automatic test_timeout_exhaust;
        int lat, nd, v, elat;
        bit etmo, c0, c1;
        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, 1000);
        model_run(0, 1, 0, 1, 1000, elat, etmo, c0, c1);
        launch_and_wait(0, lat, nd, v);
        drop_left = 0;
        n_checks++;
        if ({b0_ok, b0_mism, b0_tmo, b0_busy} !== 4'b0010) begin
            n_fail++; $display("FAIL exhaust_status: got ok/mism/tmo/busy=%b required 0010", {b0_ok, b0_mism, b0_tmo, b0_busy});
        end
        n_checks++;
        if (lat !== elat || nd !== 1) begin
            n_fail++; $display("FAIL exhaust_timing: got latency %0d pulses %0d required %0d 1", lat, nd, elat);
        end
        $display("exhaust: latency %0d (model %0d)", lat, elat);
    endtask

    task automatic test_retry;
        int lat, nd, v, elat;
        bit etmo, c0, c1;
        int drops [2] = '{1, 3};
        foreach (drops[k]) begin
            set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, drops[k]);
            model_run(0, 1, 0, 1, drops[k], elat, etmo, c0, c1);
            launch_and_wait(0, lat, nd, v);
            n_checks++;
            if (lat !== elat || {b0_ok, b0_tmo} !== 2'b10) begin
                n_fail++; $display("FAIL retry_drop%0d: got latency %0d ok/tmo=%b required %0d 10", drops[k], lat, {b0_ok, b0_tmo}, elat);
            end
            $display("retry: %0d dropped reads, latency %0d", drops[k], lat);
        end
        set_slave(0, T - 1, 0, 1, EXP_ID, EXP_TS, 0);
        model_run(0, T - 1, 0, 1, 0, elat, etmo, c0, c1);
        launch_and_wait(0, lat, nd, v);
        n_checks++;
        if (lat !== elat || {b0_ok, b0_tmo} !== 2'b10) begin
            n_fail++; $display("FAIL coincident_resp: got latency %0d ok/tmo=%b required %0d 10", lat, {b0_ok, b0_tmo}, elat);
        end
        $display("coincident: latency %0d (model %0d)", lat, elat);
    endtask

    task automatic test_random;
        int lat, nd, v, elat, s0, s1, d0, d1, drop, pick;
        bit etmo, c0, c1, eok;
        logic [31:0] id, ts;
        for (int it = 0; it < 24; it++) begin
            id = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            ts = ($urandom_range(0, 1) == 1) ? EXP_TS : EXP_TS ^ (32'd1 << $urandom_range(0, 31));
            s0 = $urandom_range(0, 4); s1 = $urandom_range(0, 4);
            d0 = $urandom_range(1, 5); d1 = $urandom_range(1, 5);
            pick = $urandom_range(0, 9);
            if (pick == 0) d1 = T - s1;
            if (pick == 1) d0 = T - 1 - s0;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            set_slave(s0, d0, s1, d1, id, ts, drop);
            model_run(s0, d0, s1, d1, drop, elat, etmo, c0, c1);
            eok = !etmo && (id == EXP_ID) && (ts == EXP_TS);
            launch_and_wait(0, lat, nd, v);
            drop_left = 0;
            n_checks++;
            if ({b0_ok, b0_mism, b0_tmo} !== {eok, !etmo && !eok, etmo}) begin
                n_fail++; $display("FAIL rand%0d_status: got ok/mism/tmo=%b required %b", it, {b0_ok, b0_mism, b0_tmo}, {eok, !etmo && !eok, etmo});
            end
            n_checks++;
            if (lat !== elat || nd !== 1) begin
                n_fail++; $display("FAIL rand%0d_timing: got latency %0d pulses %0d required %0d 1", it, lat, nd, elat);
            end
            if (c0) begin
                n_checks++;
                if (b0_id !== id) begin
                    n_fail++; $display("FAIL rand%0d_id: got %h required %h", it, b0_id, id);
                end
            end
            if (c1) begin
                n_checks++;
                if (b0_ts !== ts) begin
                    n_fail++; $display("FAIL rand%0d_ts: got %h required %h", it, b0_ts, ts);
                end
            end
            $display("rand %0d: s=%0d/%0d d=%0d/%0d drop=%0d latency=%0d ok=%b tmo=%b", it, s0, s1, d0, d1, drop, lat, b0_ok, b0_tmo);
        end
    endtask

    task automatic test_start_during_busy;
        int lat, nd, v;
        set_slave(0, 1, 0, 1, EXP_ID, EXP_TS, 0);
        launch_and_wait(1, lat, nd, v);
        repeat (10) begin
            @(negedge clk); #1;
            if (b0_done === 1'b1) nd++;
        end
        n_checks++;
        if (nd !== 1 || lat !== 6 || b0_busy !== 1'b0) begin
            n_fail++; $display("FAIL start_while_busy: got %0d pulses latency %0d busy %b required 1 6 0", nd, lat, b0_busy);
        end
        $display("start held while busy: done pulses %0d", nd);
    endtask

    task automatic test_reset_midread;
        logic [31:0] w0, late;
        int bad;
        w0 = $urandom | 32'h1; late = $urandom | 32'h1; bad = 0;
        @(negedge clk); #1; s1_start = 1'b1;
        @(negedge clk); #1; s1_start = 1'b0;
        @(negedge clk); #1; a1_rdv = 1'b1; a1_rdata = w0;
        @(negedge clk); #1; a1_rdv = 1'b0;
        n_checks++;
        if (b1_id !== w0) begin
            n_fail++; $display("FAIL midread_capture: got %h required %h", b1_id, w0);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({b1_busy, a1_read, a1_addr} !== 3'b101) begin
            n_fail++; $display("FAIL midread_in_rd1_wait: got busy/read/addr=%b required 101", {b1_busy, a1_read, a1_addr});
        end
        rst1_n = 1'b0;
        #1;
        n_checks++;
        if ({b1_busy, b1_done, b1_ok, b1_mism, b1_tmo, a1_read} !== 6'b0 || b1_id !== 32'd0) begin
            n_fail++; $display("FAIL midread_async_clear: got flags %b id %h required 0", {b1_busy, b1_done, b1_ok, b1_mism, b1_tmo, a1_read}, b1_id);
        end
        @(negedge clk); #1; rst1_n = 1'b1;
        @(negedge clk); #1; a1_rdv = 1'b1; a1_rdata = late;
        @(negedge clk); #1; a1_rdv = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            if ({b1_busy, b1_done, a1_read} !== 3'b0 || b1_ts !== 32'd0 || b1_id !== 32'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL late_resp_ignored: got %0d disturbed cycles required 0", bad);
        end
        $display("reset mid-read: late response discarded");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_autostart();
        test_mismatch();
        test_stall();
        test_timeout_exhaust();
        test_retry();
        test_random();
        test_start_during_busy();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
